// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin arbiter for the shared tri-state snoop bus.
// Holds the grant across bus_busy transactions and revokes an idle owner
// after MAX_TENURE cycles while others wait. A one-cycle turnaround (TURN)
// separates consecutive grants.
// Optional feature macro: ARB_PRIO_CLASS_EN adds hi_prio_mask, which gives
// a high-priority class precedence in arbitration and in tenure revocation.
module snoop_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MAX_TENURE = 64,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] bus_req,
    input  logic               bus_busy,
`ifdef ARB_PRIO_CLASS_EN
    input  logic [NUM_REQ-1:0] hi_prio_mask,
`endif
    output logic [NUM_REQ-1:0] bus_grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic               tenure_timeout
);

    localparam int CNT_W = (MAX_TENURE > 0) ? $clog2(MAX_TENURE + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TENURE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   tenure_cnt, tenure_nxt;
    logic [ID_W-1:0]    last_winner, last_nxt;
    logic [ID_W-1:0]    id_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic               timeout_nxt;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] rivals;
    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic [ID_W-1:0]    scan_idx;
    logic               owner_release;
    logic               revoke_hit;

    // Saturating increment of the tenure counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Eligible request set and the waiting requesters that may force revocation.
`ifdef ARB_PRIO_CLASS_EN
    logic owner_hi;
    always_comb begin
        owner_hi = |(bus_grant & hi_prio_mask);
        arb_req  = ((bus_req & hi_prio_mask) != '0) ? (bus_req & hi_prio_mask) : bus_req;
        rivals   = owner_hi ? (bus_req & ~bus_grant & hi_prio_mask)
                            : (bus_req & ~bus_grant);
    end
`else
    always_comb begin
        arb_req = bus_req;
        rivals  = bus_req & ~bus_grant;
    end
`endif

    // Round-robin pick: first eligible index after last_winner, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last_winner;
        scan_idx   = last_winner;
        for (int i = NUM_REQ; i >= 1; i--) begin
            scan_idx = ID_W'((int'(last_winner) + i) % NUM_REQ);
            if (arb_req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // Owner-side release and revocation conditions.
    always_comb begin
        owner_release = !bus_req[grant_id] && !bus_busy;
        revoke_hit    = (MAX_TENURE > 0) && (tenure_cnt == CNT_MAX) && (rivals != '0);
    end

    // Next-state and next-output logic for the IDLE/OWN/TURN machine.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = bus_grant;
        id_nxt      = grant_id;
        last_nxt    = last_winner;
        tenure_nxt  = tenure_cnt;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                grant_nxt = '0;
                if (pick_found) begin
                    state_nxt  = OWN;
                    grant_nxt  = NUM_REQ'(1) << pick_idx;
                    id_nxt     = pick_idx;
                    last_nxt   = pick_idx;
                    tenure_nxt = '0;
                end
            end
            OWN: begin
                if (owner_release) begin
                    // Normal release takes precedence over a coincident timeout.
                    state_nxt  = TURN;
                    grant_nxt  = '0;
                    tenure_nxt = '0;
                end else if (bus_busy) begin
                    // An in-flight transaction always wins over revocation.
                    tenure_nxt = '0;
                end else if (revoke_hit) begin
                    state_nxt   = TURN;
                    grant_nxt   = '0;
                    tenure_nxt  = '0;
                    timeout_nxt = 1'b1;
                end else if (rivals != '0) begin
                    tenure_nxt = sat_inc(tenure_cnt);
                end
            end
            TURN: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // State register; reset drops the grant without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered outputs, round-robin pointer and tenure counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_grant      <= '0;
            grant_valid    <= 1'b0;
            grant_id       <= '0;
            tenure_timeout <= 1'b0;
            last_winner    <= ID_W'(NUM_REQ - 1);
            tenure_cnt     <= '0;
        end else begin
            bus_grant      <= grant_nxt;
            grant_valid    <= |grant_nxt;
            grant_id       <= id_nxt;
            tenure_timeout <= timeout_nxt;
            last_winner    <= last_nxt;
            tenure_cnt     <= tenure_nxt;
        end
    end

endmodule
